seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial sequence detector: one bit per enabled clock, pattern of runtime-programmable length up to MAX_LEN, pattern value programmable at runtime.
- Overlapping or non-overlapping detection is selected at runtime.
- Flags each match with a registered one-cycle pulse and keeps a saturating match count.
- Drop-in generalisation of the team's fixed 4-bit serial detectors. Reset configuration is pattern 0110, overlapping, so existing users see identical out timing.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of length field; must hold MAX_LEN.
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  bit-valid; in is sampled only when en=1
- in  input  1  serial data bit
- cfg_load  input  1  pulse: latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  input  LEN_W  pattern length in bits
- cfg_overlap  input  1  1=overlapping, 0=non-overlapping
- cnt_clr  input  1  synchronous clear of match_cnt
- out  output  1  registered match pulse
- match_cnt  output  CNT_W  saturating match count
- fill  output  LEN_W  number of valid history bits, saturating at MAX_LEN

Behaviour:
- Reset (rst=1, synchronous, highest priority):
  - Config registers: pattern = 0110 zero-extended, len = 4, overlap = 1.
  - hist = 0, fill = 0, out = 0, match_cnt = 0.
- Config latch:
  - cfg_load=1 (rst=0) latches config and clears hist and fill to 0. out is 0 that cycle.
  - Any en/in in the same cycle is discarded. match_cnt is untouched unless cnt_clr=1.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - cfg_len = 0 disables detection: bits still shift, out stays 0.
- Bit shift (en=1, no cfg_load):
  - hist_next = {hist[MAX_LEN-2:0], in}.
  - fill_next = min(fill+1, MAX_LEN).
- Match condition, evaluated on next-state values:
  - len != 0, fill_next >= len, and hist_next[len-1:0] == pattern[len-1:0].
  - Bits above len are ignored in both hist and pattern.
- Output timing: out <= match on the same edge that samples the final pattern bit. out is high for exactly the following cycle. Latency is 0 cycles after the sampling edge, identical to the fixed 0110 detector.
- Non-overlap mode: on a match, fill is forced to 0 (hist may retain data). The next match needs len fresh bits.
- Overlap mode: fill is not cleared on a match.
- en=0: hist, fill and config are held; out <= 0. Gaps in en do not break a partially received pattern.
- match_cnt:
  - Increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0; if a match occurs in the same cycle it becomes 1.
  - rst overrides everything.
- Mode change mid-stream: only via cfg_load, which always restarts detection.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- After rst, en=1, stream 0,1,1,0,1,1,0 -> out high in the cycle after the 4th and after the 7th sampling edge (overlap); match_cnt=2.
- cfg_load pattern=0110, len=4, overlap=0; stream 0,1,1,0,1,1,0 -> single out pulse after 4th bit; match_cnt=1. Then 0,1,1,0 -> second pulse.
- cfg_load pattern=8'b10101010, len=8, overlap=1; stream 1010101010 -> pulses after bits 8 and 10; fill saturates at 8.
- Stream 0,1 with en=1, then en=0 for 5 cycles with in toggling, then en=1 with 1,0 -> exactly one pulse, after the final 0; out=0 during the gap.
- CNT_W=2, overlap pattern len=1 pattern=1; stream five 1s -> match_cnt saturates at 3. Assert cnt_clr on a matching cycle -> match_cnt=1.
- Assert rst mid-pattern after 0,1,1, then send 0 -> no pulse; out=0, fill=1, config back to 0110/4/overlap. Also check cfg_len=0 -> never pulses, and cfg_len=12 -> behaves as len=8.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Bit-stream, configuration and status bundle for the parametrised sequence detector.
// master drives stimulus and config; slave is the detector side.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic [LEN_W-1:0]   fill;

  modport master (
    output en, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  out, match_cnt, fill
  );

  modport slave (
    input  en, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output out, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Serial sequence detector with runtime pattern, length and overlap mode.
// Matches are judged on next-state history so out rises on the edge that samples the last bit.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b0110);
  localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(4);

  logic [MAX_LEN-1:0] pat_q, hist_q, hist_nx, bit_ok;
  logic [LEN_W-1:0]   len_q, fill_q, fill_nx, len_ld;
  logic               ovl_q, out_q, shift, hit;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;

  assign shift   = bus.en && !bus.cfg_load;
  assign hist_nx = {hist_q[MAX_LEN-2:0], bus.in};
  assign fill_nx = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
  assign len_ld  = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

  // Bits at or above the programmed length are don't-care.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign bit_ok[i] = (i >= int'(len_q)) || (hist_nx[i] == pat_q[i]);
  end

  assign hit = shift && (len_q != '0) && (fill_nx >= len_q) && (&bit_ok);

  always_comb begin
    cnt_nx = cnt_q;
    if (bus.cnt_clr)
      cnt_nx = hit ? CNT_W'(1) : '0;
    else if (hit && (cnt_q != '1))
      cnt_nx = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q <= hit;
      cnt_q <= cnt_nx;
      if (bus.cfg_load) begin
        pat_q  <= bus.cfg_pattern;
        len_q  <= len_ld;
        ovl_q  <= bus.cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (bus.en) begin
        hist_q <= hist_nx;
        // Non-overlap restarts the fill count so the next match needs len fresh bits.
        fill_q <= (hit && !ovl_q) ? '0 : fill_nx;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: a bit-queue reference model pushes expected out/count/fill per cycle,
// popped and compared one edge later. A CNT_W=2 copy shares the stimulus to check saturation.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) b0 ();
  seq_detect_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) b1 ();

  seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic o;
    int   c8;
    int   c2;
    int   f;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic       bits[$];
  int         m_c8, m_c2;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic apply(input logic r, input logic ld, input logic e, input logic b,
                       input logic clr, input logic [7:0] pat = 8'h00,
                       input logic [3:0] len = 4'd0, input logic ovl = 1'b0);
    logic hit;
    exp_t x;
    @(negedge clk);
    rst            = r;
    b0.en          = e;   b1.en          = e;
    b0.in          = b;   b1.in          = b;
    b0.cfg_load    = ld;  b1.cfg_load    = ld;
    b0.cfg_pattern = pat; b1.cfg_pattern = pat;
    b0.cfg_len     = len; b1.cfg_len     = len;
    b0.cfg_overlap = ovl; b1.cfg_overlap = ovl;
    b0.cnt_clr     = clr; b1.cnt_clr     = clr;
    hit = 1'b0;
    if (r) begin
      m_pat = 8'b0000_0110; m_len = 4; m_ovl = 1'b1;
      bits.delete(); m_c8 = 0; m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = pat; m_len = (len > 4'd8) ? 8 : int'(len); m_ovl = ovl;
        bits.delete();
      end else if (e) begin
        bits.push_back(b);
        if (bits.size() > 8) void'(bits.pop_front());
        if (m_len != 0 && bits.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (bits[bits.size() - m_len + k] !== m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ovl) bits.delete();
      end
      if (clr) begin
        m_c8 = int'(hit); m_c2 = int'(hit);
      end else if (hit) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    x.o = hit; x.c8 = m_c8; x.c2 = m_c2; x.f = bits.size();
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("out0", 32'(b0.out), 32'(x.o));
    chk("out1", 32'(b1.out), 32'(x.o));
    chk("cnt0", 32'(b0.match_cnt), x.c8);
    chk("cnt1", 32'(b1.match_cnt), x.c2);
    chk("fill", 32'(b0.fill), x.f);
  endtask

  task automatic sbit(input logic b);
    apply(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic stream(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, pat, len, ovl);
  endtask

  initial begin
    b0.en = 0; b0.in = 0; b0.cfg_load = 0; b0.cfg_pattern = 0; b0.cfg_len = 0;
    b0.cfg_overlap = 0; b0.cnt_clr = 0;
    b1.en = 0; b1.in = 0; b1.cfg_load = 0; b1.cfg_pattern = 0; b1.cfg_len = 0;
    b1.cfg_overlap = 0; b1.cnt_clr = 0;

    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_out", 32'(b0.out), 0);
    chk("rst_fill", 32'(b0.fill), 0);

    // default 0110 overlapping
    stream(16'b0110110, 7);
    chk("t1_cnt", 32'(b0.match_cnt), 2);

    load(8'b0110, 4'd4, 1'b0);
    stream(16'b0110110, 7);
    chk("t2_cnt_a", 32'(b0.match_cnt), 1);
    stream(16'b0110, 4);
    chk("t2_cnt_b", 32'(b0.match_cnt), 2);

    load(8'b10101010, 4'd8, 1'b1);
    stream(16'b1010101010, 10);
    chk("t3_cnt", 32'(b0.match_cnt), 2);
    chk("t3_fill", 32'(b0.fill), 8);

    // en gaps with in toggling must not break the partial pattern
    load(8'b0110, 4'd4, 1'b1);
    stream(16'b01, 2);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, logic'(i[0]), 1'b0);
    stream(16'b10, 2);
    chk("t4_cnt", 32'(b0.match_cnt), 1);

    load(8'h01, 4'd1, 1'b1);
    stream(16'b11111, 5);
    chk("t5_sat", 32'(b1.match_cnt), 3);
    chk("t5_cnt8", 32'(b0.match_cnt), 5);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clrhit", 32'(b1.match_cnt), 1);

    // reset mid-pattern restores 0110/4/overlap
    load(8'h5A, 4'd3, 1'b0);
    stream(16'b011, 3);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sbit(1'b0);
    chk("t6_out", 32'(b0.out), 0);
    chk("t6_fill", 32'(b0.fill), 1);
    stream(16'b110, 3);
    chk("t6_cnt", 32'(b0.match_cnt), 1);

    load(8'h00, 4'd0, 1'b1);
    stream(16'h0000, 12);
    chk("len0_cnt", 32'(b0.match_cnt), 0);
    chk("len0_fill", 32'(b0.fill), 8);

    load(8'b10101010, 4'd12, 1'b1);
    stream(16'b1010101010, 10);
    chk("len12_cnt", 32'(b0.match_cnt), 2);

    // randomised configs and streams against the model
    for (int blk = 0; blk < 8; blk++) begin
      load(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom));
      for (int i = 0; i < 40; i++)
        apply(1'b0, 1'b0, ($urandom_range(0, 7) != 0), 1'($urandom),
              ($urandom_range(0, 30) == 0));
    end
    load(8'b0000_0011, 4'd2, 1'b1);
    for (int i = 0; i < 40; i++)
      apply(1'b0, 1'b0, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) != 0), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
